if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
Parametrised next-generation IF/ID pipeline register between the fetch and decode stages.
- Replaces the plain always-load register with a valid/ready handshake and a 2-entry skid buffer, so fetch is never combinationally blocked by a decode stall.
- Supports branch flush, which injects a NOP bubble.
- Exposes a saturating stall-cycle counter for performance debug.

Parameters:
- ADDR_W, 32, width of npc_in/npc_out.
- INSTR_W, 32, width of instruction_in/instruction_out.
- NOP_INSTR, 32'h00000000, value driven on instruction_out when the stage is empty, flushed or in reset.
- CNT_W, 16, width of stall_cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  branch/jump redirect; kills all held and incoming instructions.
- valid_in  input  1  fetch presents a valid instruction.
- npc_in  input  ADDR_W  next PC (PC+4) from fetch.
- instruction_in  input  INSTR_W  fetched instruction word.
- ready_out  output  1  stage can accept; equals NOT skid_valid (registered state, no combinational path from ready_in).
- ready_in  input  1  decode accepts the current output this cycle.
- valid_out  output  1  npc_out/instruction_out hold a live instruction.
- npc_out  output  ADDR_W  registered next PC to decode.
- instruction_out  output  INSTR_W  registered instruction to decode.
- stall_cycles  output  CNT_W  count of cycles with valid_out=1 and ready_in=0, saturating.

Behaviour:
- Storage:
  - Main register (valid_out, npc_out, instruction_out) drives the outputs.
  - Skid register (skid_valid, skid_npc, skid_instr) is internal.
- Events:
  - accept = valid_in & ready_out.
  - drain = valid_out & ready_in.
- Reset (priority 1), applied at the clock edge while reset=1:
  - valid_out=0, npc_out=0, instruction_out=NOP_INSTR, skid_valid=0, stall_cycles=0.
  - ready_out reads 1 combinationally from skid_valid=0; any accept during reset is discarded.
- Flush (priority 2):
  - Next edge clears valid_out and skid_valid and sets instruction_out=NOP_INSTR; npc_out holds its value.
  - Same-cycle accept is discarded.
  - The stall_cycles increment for that cycle still applies.
- Normal update (priority 3). Latency is 1 cycle from accept to valid_out when the pipe is empty.
  - Main empty or drain, skid_valid=1: main <= skid; skid <= incoming if accept, else skid_valid=0.
  - Main empty or drain, skid_valid=0: main <= incoming if accept, else valid_out=0 and instruction_out=NOP_INSTR, npc_out holds.
  - Main full and no drain: main holds; if accept, skid <= incoming and skid_valid=1.
  - Accept cannot occur while skid_valid=1 (ready_out=0), so the buffer never overflows.
- Ordering:
  - Instructions leave in strict acceptance order.
  - No accepted instruction is lost or duplicated except by flush or reset.
- Back-to-back: with ready_in held at 1 and valid_in held at 1, one instruction is output per cycle and the skid stays empty.
- Stall counter:
  - Increments by 1 on each edge where valid_out=1 and ready_in=0 and reset=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Flush or reset asserted mid-stall with the skid full: both entries are dropped and ready_out=1 from the next cycle.
- Widths: payload is copied bit-exact; there is no arithmetic on npc.

Test Plan:
- Reset then pass-through:
  - Stimulus: reset 1 cycle; valid_in=1, npc_in=0x00000004, instr=0x8C090004, ready_in=1.
  - Required: the next edge gives valid_out=1, npc_out=0x4, instruction_out=0x8C090004.
  - Required: the next input (0x8, 0x01094020) appears 1 cycle later, with no bubble and ready_out constantly 1.
- Backpressure and skid:
  - Stimulus: ready_in=0 while 0x8C090004 is held; present 0x01094020.
  - Required: the skid captures it and ready_out drops to 0.
  - Required: 0xAC080008 is not accepted while ready_out=0.
  - Required: after ready_in=1, the outputs are 0x8C090004, 0x01094020, 0xAC080008 in order, one per cycle; ready_out returns to 1 after one ready_in=1 edge.
- Flush with skid full:
  - Stimulus: assert flush for 1 cycle.
  - Required: valid_out=0, instruction_out=0x00000000, npc_out unchanged, ready_out=1 next cycle.
  - Required: an accept in the flush cycle never appears at the output.
- Reset mid-stall: with 2 instructions held and stall_cycles=5, pulse reset -> all valids 0, instruction_out=NOP_INSTR, npc_out=0, stall_cycles=0.
- Counter saturation:
  - Stimulus: CNT_W=4; hold valid_out=1, ready_in=0 for 20 cycles.
  - Required: stall_cycles reaches 15 and stays 15; the count stops when ready_in=1.
- Parameter sweep:
  - Stimulus: ADDR_W=16, INSTR_W=16, NOP_INSTR=16'h0001.
  - Required: the bubble reads 0x0001, and payload 0xBEEF/0x1234 passes through unaltered.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// A branch flush kills every held instruction, and a saturating counter records decode stalls.
module if_id_skid_reg #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [ADDR_W-1:0]  npc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               ready_out,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [ADDR_W-1:0]  npc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic               skid_valid;
  logic [ADDR_W-1:0]  skid_npc;
  logic [INSTR_W-1:0] skid_instr;

  logic accept;
  logic load_main;
  logic stalled;

  // ready_out is pure state, so ready_in never reaches fetch combinationally
  assign ready_out = ~skid_valid;
  assign accept    = valid_in & ready_out;
  assign load_main = ~valid_out | ready_in;
  assign stalled   = valid_out & ~ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out       <= 1'b0;
      npc_out         <= '0;
      instruction_out <= NOP_INSTR;
      skid_valid      <= 1'b0;
      skid_npc        <= '0;
      skid_instr      <= NOP_INSTR;
    end else if (flush) begin
      valid_out       <= 1'b0;
      instruction_out <= NOP_INSTR;
      skid_valid      <= 1'b0;
    end else begin
      unique case (1'b1)
        load_main && skid_valid: begin
          valid_out       <= 1'b1;
          npc_out         <= skid_npc;
          instruction_out <= skid_instr;
          skid_valid      <= accept;
          if (accept) begin
            skid_npc   <= npc_in;
            skid_instr <= instruction_in;
          end
        end
        load_main && !skid_valid: begin
          valid_out <= accept;
          if (accept) begin
            npc_out         <= npc_in;
            instruction_out <= instruction_in;
          end else begin
            instruction_out <= NOP_INSTR;
          end
        end
        !load_main: begin
          if (accept) begin
            skid_valid <= 1'b1;
            skid_npc   <= npc_in;
            skid_instr <= instruction_in;
          end
        end
      endcase
    end
  end

  // counts through flush too; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stalled && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a queue model of held instructions,
// checked against a 32-bit/CNT_W=4 instance and a 16-bit instance fed in lockstep.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] npc_in = '0;
  logic [31:0] instruction_in = '0;
  logic        ready_in = 1'b1;

  logic        ready_out, valid_out;
  logic [31:0] npc_out, instruction_out;
  logic [3:0]  stall_cycles;

  logic        ready16, valid16;
  logic [15:0] npc16, instr16, stall16;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] ins;
  } item_t;

  item_t q[$];
  int    stall_e = 0;
  int    stall16_e = 0;
  logic [31:0] npc_e = '0;

  always #5 clk = ~clk;

  if_id_skid_reg #(
    .ADDR_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .npc_in(npc_in),
    .instruction_in(instruction_in),
    .ready_out(ready_out), .ready_in(ready_in),
    .valid_out(valid_out), .npc_out(npc_out),
    .instruction_out(instruction_out),
    .stall_cycles(stall_cycles)
  );

  if_id_skid_reg #(
    .ADDR_W(16), .INSTR_W(16), .NOP_INSTR(16'h0001), .CNT_W(16)
  ) dut16 (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .npc_in(npc_in[15:0]),
    .instruction_in(instruction_in[15:0]),
    .ready_out(ready16), .ready_in(ready_in),
    .valid_out(valid16), .npc_out(npc16),
    .instruction_out(instr16),
    .stall_cycles(stall16)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage holds at most two instructions in FIFO order.
  always @(posedge clk) begin
    int  n;
    bit  acc;
    n = q.size();
    if (reset) begin
      q.delete();
      stall_e = 0;
      stall16_e = 0;
      npc_e = '0;
    end else begin
      if (n > 0 && !ready_in) begin
        if (stall_e < 15) stall_e++;
        if (stall16_e < 65535) stall16_e++;
      end
      if (flush) begin
        q.delete();
      end else begin
        acc = valid_in && (n < 2);
        if (n > 0 && ready_in) void'(q.pop_front());
        if (acc) q.push_back('{npc_in, instruction_in});
      end
      if (q.size() > 0) npc_e = q[0].npc;
    end
  end

  // Monitor: compares what both instances present against the model.
  always @(negedge clk) begin
    bit          v;
    logic [31:0] ins_e;
    v = q.size() > 0;
    ins_e = v ? q[0].ins : 32'h0;
    chk("valid_out", {31'b0, valid_out}, {31'b0, v});
    chk("ready_out", {31'b0, ready_out}, {31'b0, q.size() < 2});
    chk("npc_out", npc_out, npc_e);
    chk("instruction_out", instruction_out, ins_e);
    chk("stall_cycles", {28'b0, stall_cycles}, stall_e);
    chk("valid16", {31'b0, valid16}, {31'b0, v});
    chk("ready16", {31'b0, ready16}, {31'b0, q.size() < 2});
    chk("npc16", {16'b0, npc16}, {16'b0, npc_e[15:0]});
    chk("instr16", {16'b0, instr16},
        v ? {16'b0, ins_e[15:0]} : 32'h0000_0001);
    chk("stall16", {16'b0, stall16}, stall16_e);
  end

  task automatic step(input bit r, input bit f, input bit v,
                      input logic [31:0] n, input logic [31:0] i,
                      input bit rdy);
    @(negedge clk);
    reset = r;
    flush = f;
    valid_in = v;
    npc_in = n;
    instruction_in = i;
    ready_in = rdy;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset then pass-through
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h4, 32'h8C09_0004, 1);
    after_edge();
    chk("pt_valid", {31'b0, valid_out}, 32'h1);
    chk("pt_npc", npc_out, 32'h4);
    chk("pt_instr", instruction_out, 32'h8C09_0004);
    step(0, 0, 1, 32'h8, 32'h0109_4020, 1);
    after_edge();
    chk("pt_instr2", instruction_out, 32'h0109_4020);
    chk("pt_ready", {31'b0, ready_out}, 32'h1);
    step(0, 0, 0, 0, 0, 1);

    // backpressure and skid
    step(0, 0, 1, 32'h4, 32'h8C09_0004, 0);
    step(0, 0, 1, 32'h8, 32'h0109_4020, 0);
    after_edge();
    chk("skid_ready", {31'b0, ready_out}, 32'h0);
    step(0, 0, 1, 32'hC, 32'hAC08_0008, 0);
    step(0, 0, 1, 32'hC, 32'hAC08_0008, 0);
    step(0, 0, 1, 32'hC, 32'hAC08_0008, 1);
    after_edge();
    chk("skid_out2", instruction_out, 32'h0109_4020);
    chk("skid_ready_back", {31'b0, ready_out}, 32'h1);
    step(0, 0, 1, 32'hC, 32'hAC08_0008, 1);
    after_edge();
    chk("skid_out3", instruction_out, 32'hAC08_0008);
    step(0, 0, 0, 0, 0, 1);

    // flush with skid full, plus an incoming accept that must vanish
    step(0, 0, 1, 32'h10, 32'h1111_1111, 0);
    step(0, 0, 1, 32'h14, 32'h2222_2222, 0);
    step(0, 1, 1, 32'h18, 32'hDEAD_BEEF, 0);
    after_edge();
    chk("fl_valid", {31'b0, valid_out}, 32'h0);
    chk("fl_instr", instruction_out, 32'h0);
    chk("fl_npc", npc_out, 32'h10);
    chk("fl_ready", {31'b0, ready_out}, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // reset mid-stall
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h20, 32'h3333_3333, 0);
    step(0, 0, 1, 32'h24, 32'h4444_4444, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("rs_stall5", {28'b0, stall_cycles}, 32'd5);
    step(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("rs_valid", {31'b0, valid_out}, 32'h0);
    chk("rs_npc", npc_out, 32'h0);
    chk("rs_instr", instruction_out, 32'h0);
    chk("rs_stall", {28'b0, stall_cycles}, 32'h0);
    chk("rs_ready", {31'b0, ready_out}, 32'h1);

    // counter saturation
    step(0, 0, 1, 32'h1234_BEEF, 32'h5A5A_1234, 1);
    repeat (20) step(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("sat_15", {28'b0, stall_cycles}, 32'd15);
    chk("sat_npc16", {16'b0, npc16}, 32'h0000_BEEF);
    chk("sat_instr16", {16'b0, instr16}, 32'h0000_1234);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    after_edge();
    chk("sat_hold", {28'b0, stall_cycles}, 32'd15);
    chk("bubble16", {16'b0, instr16}, 32'h0000_0001);

    // randomized traffic
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0,
           $urandom, $urandom,
           $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
